// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, resolves unconditional B/BL in fetch,
// and fills the IF/ID register; downstream redirects flush the slot.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [63:0] id_pc_plus4,
  output logic [31:0] fetch_cnt
);

  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic [63:0] plus4_q, plus4_d;
  logic [31:0] cnt_q, cnt_d;

  logic [5:0]  opcode;
  logic        is_branch;
  logic [63:0] br_offset;
  logic [63:0] br_target;
  logic [63:0] pc_plus4;

  assign opcode    = imem_instr[31:26];
  assign is_branch = (opcode == 6'b000101) || (opcode == 6'b100101);
  // imm26 is a word offset: sign-extend, then scale to bytes
  assign br_offset = {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00};
  assign br_target = pc_q + br_offset;
  assign pc_plus4  = pc_q + 64'd4;

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    plus4_d = plus4_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      // Redirect beats stall; id_pc/id_pc_plus4 keep their stale values
      pc_d    = {redirect_pc[63:2], 2'b00};
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      valid_d = 1'b1;
      instr_d = imem_instr;
      id_pc_d = pc_q;
      plus4_d = pc_plus4;
      cnt_d   = cnt_q + 32'd1;
      pc_d    = is_branch ? br_target : pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      id_pc_q <= 64'h0;
      plus4_q <= 64'h0;
      cnt_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      plus4_q <= plus4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = plus4_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: an arithmetic reference model driven by random
// stall/redirect traffic plus directed literal checks of the key scenarios.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
  logic [31:0] fetch_cnt;

  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [63:0] redirect_pc2 = 64'h0;
  logic [31:0] imem_instr2 = 32'h0;
  logic [63:0] imem_addr2;
  logic        id_valid2;
  logic [31:0] id_instr2;
  logic [63:0] id_pc2;
  logic [63:0] id_pc_plus4_2;
  logic [31:0] fetch_cnt2;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  logic [63:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_idpc;
  logic [63:0] m_plus4;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instr_fetch #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fetch_cnt(fetch_cnt)
  );

  instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2),
    .id_pc_plus4(id_pc_plus4_2), .fetch_cnt(fetch_cnt2)
  );

  // Where the PC goes after fetching word w at pc, in plain signed arithmetic
  function automatic logic [63:0] model_next_pc(input logic [63:0] pc, input logic [31:0] w);
    longint off;
    if (w[31:26] == 6'd5 || w[31:26] == 6'd37) begin
      off = longint'($signed(w[25:0]));
      return pc + 64'(off * 4);
    end
    return pc + 64'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= 64'h0;
      m_valid <= 1'b0;
      m_instr <= NOP;
      m_idpc  <= 64'h0;
      m_plus4 <= 64'h0;
      m_cnt   <= 32'h0;
    end else if (redirect) begin
      m_pc    <= redirect_pc & ~64'd3;
      m_valid <= 1'b0;
      m_instr <= NOP;
    end else if (!stall) begin
      m_valid <= 1'b1;
      m_instr <= mem[m_pc[9:2]];
      m_idpc  <= m_pc;
      m_plus4 <= m_pc + 64'd4;
      m_cnt   <= m_cnt + 32'd1;
      m_pc    <= model_next_pc(m_pc, mem[m_pc[9:2]]);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model imem_addr", imem_addr, m_pc);
      checkOutput("model id_valid", 64'(id_valid), 64'(m_valid));
      checkOutput("model id_instr", 64'(id_instr), 64'(m_instr));
      checkOutput("model id_pc", id_pc, m_idpc);
      checkOutput("model id_pc_plus4", id_pc_plus4, m_plus4);
      checkOutput("model fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    end
  end

  task automatic applyStimulus(input logic st, input logic rd, input logic [63:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic checkResetLiterals(input string tag);
    checkOutput({tag, " imem_addr"}, imem_addr, 64'h0);
    checkOutput({tag, " id_valid"}, 64'(id_valid), 64'h0);
    checkOutput({tag, " id_instr"}, 64'(id_instr), 64'(NOP));
    checkOutput({tag, " id_pc"}, id_pc, 64'h0);
    checkOutput({tag, " id_pc_plus4"}, id_pc_plus4, 64'h0);
    checkOutput({tag, " fetch_cnt"}, 64'(fetch_cnt), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h8B00_0000 | 32'(i);
    mem[8]  = 32'h1400_0003;
    mem[11] = 32'h17FF_FFFF;

    #1 reset = 1'b0;
    #2 checkResetLiterals("reset");
    checkOutput("wrap reset imem_addr", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_en = 1'b1;

    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("first id_valid", 64'(id_valid), 64'h1);
    checkOutput("first id_pc", id_pc, 64'h0);
    checkOutput("wrap id_pc", id_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap id_pc_plus4", id_pc_plus4_2, 64'h0);
    checkOutput("wrap imem_addr", imem_addr2, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("seq imem_addr", imem_addr, 64'h10);
    checkOutput("seq fetch_cnt", 64'(fetch_cnt), 64'd4);
    checkOutput("seq id_pc", id_pc, 64'hC);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("stall imem_addr", imem_addr, 64'h10);
    checkOutput("stall fetch_cnt", 64'(fetch_cnt), 64'd4);
    checkOutput("stall id_pc", id_pc, 64'hC);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("resume imem_addr", imem_addr, 64'h14);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("B fwd imem_addr", imem_addr, 64'h2C);
    checkOutput("B fwd id_instr", 64'(id_instr), 64'h1400_0003);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("B back imem_addr", imem_addr, 64'h28);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("pre-redirect fetch_cnt", 64'(fetch_cnt), 64'd11);

    applyStimulus(1'b1, 1'b1, 64'h103);
    checkOutput("redirect imem_addr", imem_addr, 64'h100);
    checkOutput("redirect id_valid", 64'(id_valid), 64'h0);
    checkOutput("redirect id_instr", 64'(id_instr), 64'(NOP));
    checkOutput("redirect fetch_cnt", 64'(fetch_cnt), 64'd11);
    checkOutput("redirect id_pc hold", id_pc, 64'h28);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("post-redirect id_pc", id_pc, 64'h100);
    checkOutput("post-redirect id_valid", 64'(id_valid), 64'h1);
    checkOutput("post-redirect fetch_cnt", 64'(fetch_cnt), 64'd12);

    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      int d;
      int k;
      r = $urandom;
      k = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 40)) - 20;
      if (k == 0) r = {6'b000101, 26'(d)};
      else if (k == 1) r = {6'b100101, 26'(d)};
      else if (r[31:26] == 6'b000101 || r[31:26] == 6'b100101) r[30] = ~r[30];
      mem[i] = r;
    end

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 reset = 1'b0;
        #1 checkResetLiterals("async reset");
        @(negedge clk);
        reset = 1'b1;
      end
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    {$urandom, $urandom});
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
